mem_stage: RTL and testbench

//  MEM pipeline stage of the 5-stage MIPS core; sits between EX/MEM and the writeback stage.

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/mem_stage_if.sv | 25 ++
 rtl/mem_wb_reg.sv | 46 ++++
 rtl/mem_stage.sv | 183 ++++++++++++++++++
 tb/tb_mem_stage.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM states, exception codes,
// MEM/WB bundle layout and default timing parameters.
package mem_pkg;

  localparam int ACK_TIMEOUT_DEF = 64;
  localparam int DATA_W          = 32;
  localparam int REG_W           = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_MISALIGN = 2'd1,
    EXC_TIMEOUT  = 2'd2,
    EXC_ILLEGAL  = 2'd3
  } exc_e;

  typedef struct packed {
    logic rg_wr;
    logic rg_wr_imm;
    logic mem_rd;
  } wb_ctrl_t;

  typedef struct packed {
    wb_ctrl_t              ctrl;
    logic [REG_W-1:0]      rt;
    logic [REG_W-1:0]      rd;
    logic [DATA_W-1:0]     alu_data;
    logic [DATA_W-1:0]     mem_rd_data;
  } wb_bundle_t;

  // Only word accesses exist, so any low address bit set is a misalignment.
  function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and
// the data memory (slave).
interface mem_stage_if #(
  parameter int AW = 32
) ();
  import mem_pkg::*;

  logic              dm_req;
  logic              dm_we;
  logic [AW-1:0]     dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Loads a full bundle when enabled; otherwise emits a
// bubble (valid and controls cleared) while the data fields keep their value.
module mem_wb_reg
  import mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       load_i,
  input  logic       bubble_i,
  input  exc_e       exc_i,
  input  wb_bundle_t bundle_i,
  output logic       valid_o,
  output exc_e       exc_o,
  output wb_bundle_t bundle_o
);

  logic       valid_q;
  exc_e       exc_q;
  wb_bundle_t bundle_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q  <= 1'b0;
      exc_q    <= EXC_NONE;
      bundle_q <= '0;
    end else if (load_i) begin
      valid_q              <= 1'b1;
      exc_q                <= exc_i;
      // Exception bundles still occupy the slot but must never write back.
      bundle_q.ctrl        <= bubble_i ? wb_ctrl_t'('0) : bundle_i.ctrl;
      bundle_q.rt          <= bundle_i.rt;
      bundle_q.rd          <= bundle_i.rd;
      bundle_q.alu_data    <= bundle_i.alu_data;
      bundle_q.mem_rd_data <= bundle_i.mem_rd_data;
    end else begin
      valid_q       <= 1'b0;
      exc_q         <= EXC_NONE;
      bundle_q.ctrl <= '0;
    end
  end

  assign valid_o  = valid_q;
  assign exc_o    = exc_q;
  assign bundle_o = bundle_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS core: word loads/stores over a req/ack bus,
// pipeline stall while an access is outstanding, registered MEM/WB output.
module mem_stage
  import mem_pkg::*;
#(
  parameter int AW          = 32,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_rg_wr,
  input  logic                i_rg_wr_imm,
  input  logic                i_mem_rd,
  input  logic                i_mem_wr,
  input  logic [REG_W-1:0]    i_rt,
  input  logic [REG_W-1:0]    i_rd,
  input  logic [DATA_W-1:0]   i_alu_data,
  input  logic [DATA_W-1:0]   i_st_data,
  mem_stage_if.master         dm,
  output logic                o_valid,
  output logic                o_rg_wr,
  output logic                o_rg_wr_imm,
  output logic                o_mem_rd,
  output logic [REG_W-1:0]    o_rt,
  output logic [REG_W-1:0]    o_rd,
  output logic [DATA_W-1:0]   o_alu_data,
  output logic [DATA_W-1:0]   o_mem_rd_data,
  output logic [1:0]          o_exc
);

  localparam int              CNT_W    = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  wb_ctrl_t           pend_ctrl_q, pend_ctrl_d;
  logic [REG_W-1:0]   pend_rt_q, pend_rt_d;
  logic [REG_W-1:0]   pend_rd_q, pend_rd_d;
  logic [DATA_W-1:0]  pend_alu_q, pend_alu_d;

  logic               accept;
  logic               wb_load;
  logic               wb_bubble;
  exc_e               wb_exc;
  wb_bundle_t         wb_in;
  logic               wb_valid;
  exc_e               wb_exc_out;
  wb_bundle_t         wb_out;

  assign o_ready = (state_q == ST_IDLE);
  assign accept  = i_valid & o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      pend_ctrl_q <= '0;
      pend_rt_q   <= '0;
      pend_rd_q   <= '0;
      pend_alu_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      pend_ctrl_q <= pend_ctrl_d;
      pend_rt_q   <= pend_rt_d;
      pend_rd_q   <= pend_rd_d;
      pend_alu_q  <= pend_alu_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    pend_ctrl_d = pend_ctrl_q;
    pend_rt_d   = pend_rt_q;
    pend_rd_d   = pend_rd_q;
    pend_alu_d  = pend_alu_q;
    wb_load     = 1'b0;
    wb_bubble   = 1'b0;
    wb_exc      = EXC_NONE;
    wb_in.ctrl        = '{rg_wr: i_rg_wr, rg_wr_imm: i_rg_wr_imm, mem_rd: i_mem_rd};
    wb_in.rt          = i_rt;
    wb_in.rd          = i_rd;
    wb_in.alu_data    = i_alu_data;
    wb_in.mem_rd_data = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!(i_mem_rd | i_mem_wr)) begin
            wb_load = 1'b1;
          end else if (i_mem_rd & i_mem_wr) begin
            wb_load   = 1'b1;
            wb_bubble = 1'b1;
            wb_exc    = EXC_ILLEGAL;
          end else if (is_misaligned(i_alu_data)) begin
            wb_load   = 1'b1;
            wb_bubble = 1'b1;
            wb_exc    = EXC_MISALIGN;
          end else begin
            state_d     = ST_ACCESS;
            cnt_d       = '0;
            req_d       = 1'b1;
            we_d        = i_mem_wr;
            wdata_d     = i_st_data;
            // Stores never write back, so their controls are dropped here.
            pend_ctrl_d = i_mem_wr ? wb_ctrl_t'('0) : wb_in.ctrl;
            pend_rt_d   = i_rt;
            pend_rd_d   = i_rd;
            pend_alu_d  = i_alu_data;
          end
        end
      end

      ST_ACCESS: begin
        wb_in.ctrl     = pend_ctrl_q;
        wb_in.rt       = pend_rt_q;
        wb_in.rd       = pend_rd_q;
        wb_in.alu_data = pend_alu_q;
        // Ack is checked first so a late ack in the last cycle beats the timeout.
        if (dm.dm_ack) begin
          state_d           = ST_IDLE;
          req_d             = 1'b0;
          wb_load           = 1'b1;
          wb_in.mem_rd_data = pend_ctrl_q.mem_rd ? dm.dm_rdata : '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          req_d     = 1'b0;
          wb_load   = 1'b1;
          wb_bubble = 1'b1;
          wb_exc    = EXC_TIMEOUT;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  mem_wb_reg u_mem_wb_reg (
    .clk_i    (i_clk),
    .rst_n_i  (i_rst_n),
    .load_i   (wb_load),
    .bubble_i (wb_bubble),
    .exc_i    (wb_exc),
    .bundle_i (wb_in),
    .valid_o  (wb_valid),
    .exc_o    (wb_exc_out),
    .bundle_o (wb_out)
  );

  assign dm.dm_req    = req_q;
  assign dm.dm_we     = we_q;
  assign dm.dm_addr   = pend_alu_q[AW-1:0];
  assign dm.dm_wdata  = wdata_q;

  assign o_valid       = wb_valid;
  assign o_exc         = wb_exc_out;
  assign o_rg_wr       = wb_out.ctrl.rg_wr;
  assign o_rg_wr_imm   = wb_out.ctrl.rg_wr_imm;
  assign o_mem_rd      = wb_out.ctrl.mem_rd;
  assign o_rt          = wb_out.rt;
  assign o_rd          = wb_out.rd;
  assign o_alu_data    = wb_out.alu_data;
  assign o_mem_rd_data = wb_out.mem_rd_data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// instructions, each compared against a transaction-level reference model.
module tb_mem_stage;
  import mem_pkg::*;

  localparam int TO = 64;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_rg_wr = 1'b0, i_rg_wr_imm = 1'b0, i_mem_rd = 1'b0, i_mem_wr = 1'b0;
  logic [4:0]  i_rt = '0, i_rd = '0;
  logic [31:0] i_alu_data = '0, i_st_data = '0;
  logic        o_valid, o_rg_wr, o_rg_wr_imm, o_mem_rd;
  logic [4:0]  o_rt, o_rd;
  logic [31:0] o_alu_data, o_mem_rd_data;
  logic [1:0]  o_exc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  mem_stage_if #(.AW(32)) dm_if ();

  mem_stage #(.AW(32), .ACK_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_rg_wr(i_rg_wr), .i_rg_wr_imm(i_rg_wr_imm), .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr),
    .i_rt(i_rt), .i_rd(i_rd), .i_alu_data(i_alu_data), .i_st_data(i_st_data),
    .dm(dm_if.master),
    .o_valid(o_valid), .o_rg_wr(o_rg_wr), .o_rg_wr_imm(o_rg_wr_imm), .o_mem_rd(o_mem_rd),
    .o_rt(o_rt), .o_rd(o_rd), .o_alu_data(o_alu_data), .o_mem_rd_data(o_mem_rd_data),
    .o_exc(o_exc)
  );

  typedef struct {
    logic        rg_wr, rg_wr_imm, mem_rd, mem_wr;
    logic [4:0]  rt, rd;
    logic [31:0] alu, st, rdata;
    int          delay;   // cycles after first req cycle until ack; >= TO means never
  } op_t;

  typedef struct {
    logic [1:0]  exc;
    logic        rg_wr, rg_wr_imm, mem_rd;
    logic [31:0] ld;
    int          stall;
    bit          bus;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Outcome of one instruction derived directly from the stage's rules.
  function automatic exp_t model(input op_t op);
    exp_t e;
    bit   is_mem;
    bit   writes_back;
    is_mem  = op.mem_rd | op.mem_wr;
    e.exc   = 2'd0;
    e.bus   = 1'b0;
    e.stall = 0;
    if (op.mem_rd && op.mem_wr) begin
      e.exc = 2'd3;
    end else if (is_mem && (op.alu % 4 != 0)) begin
      e.exc = 2'd1;
    end else if (is_mem) begin
      e.bus   = 1'b1;
      e.stall = ((op.delay < TO) ? op.delay : TO - 1) + 1;
      if (op.delay >= TO) e.exc = 2'd2;
    end
    writes_back = (e.exc == 2'd0) && !op.mem_wr;
    e.rg_wr     = writes_back & op.rg_wr;
    e.rg_wr_imm = writes_back & op.rg_wr_imm;
    e.mem_rd    = writes_back & op.mem_rd;
    e.ld        = (writes_back && op.mem_rd) ? op.rdata : 32'h0;
    return e;
  endfunction

  task automatic run_txn(input string tag, input op_t op);
    exp_t e;
    int   stall;
    bit   seen;
    e     = model(op);
    stall = 0;
    seen  = 1'b0;
    chk({tag, "_ready_pre"}, o_ready, 1);
    i_valid = 1'b1; i_rg_wr = op.rg_wr; i_rg_wr_imm = op.rg_wr_imm;
    i_mem_rd = op.mem_rd; i_mem_wr = op.mem_wr; i_rt = op.rt; i_rd = op.rd;
    i_alu_data = op.alu; i_st_data = op.st;
    step();
    for (int cyc = 0; cyc < TO + 4; cyc++) begin
      if (o_valid) begin
        seen = 1'b1;
        break;
      end
      chk({tag, "_req"}, dm_if.dm_req, 1);
      chk({tag, "_we"}, dm_if.dm_we, op.mem_wr);
      chk({tag, "_addr"}, dm_if.dm_addr, op.alu);
      if (op.mem_wr) chk({tag, "_wdata"}, dm_if.dm_wdata, op.st);
      chk({tag, "_ready_stall"}, o_ready, 0);
      stall++;
      if (cyc == op.delay) begin
        dm_if.dm_ack   = 1'b1;
        dm_if.dm_rdata = op.rdata;
      end
      step();
      dm_if.dm_ack   = 1'b0;
      dm_if.dm_rdata = $urandom;
    end
    i_valid = 1'b0;
    chk({tag, "_valid"}, seen, 1);
    chk({tag, "_stall"}, stall, e.stall);
    chk({tag, "_exc"}, o_exc, e.exc);
    chk({tag, "_rg_wr"}, o_rg_wr, e.rg_wr);
    chk({tag, "_rg_wr_imm"}, o_rg_wr_imm, e.rg_wr_imm);
    chk({tag, "_mem_rd"}, o_mem_rd, e.mem_rd);
    chk({tag, "_ld"}, o_mem_rd_data, e.ld);
    chk({tag, "_req_done"}, dm_if.dm_req, 0);
    chk({tag, "_ready_done"}, o_ready, 1);
    if (e.exc == 2'd0) begin
      chk({tag, "_rt"}, o_rt, op.rt);
      chk({tag, "_rd"}, o_rd, op.rd);
      chk({tag, "_alu"}, o_alu_data, op.alu);
    end
    step();
    chk({tag, "_bubble_valid"}, o_valid, 0);
    chk({tag, "_bubble_exc"}, o_exc, 0);
    chk({tag, "_bubble_ctrl"}, {o_rg_wr, o_rg_wr_imm, o_mem_rd}, 0);
    if (e.exc == 2'd0) chk({tag, "_hold_alu"}, o_alu_data, op.alu);
    $display("txn %s: rd=%0b wr=%0b addr=0x%08h delay=%0d exc=%0d stall=%0d",
             tag, op.mem_rd, op.mem_wr, op.alu, op.delay, e.exc, e.stall);
  endtask

  function automatic op_t blank_op();
    op_t o;
    o.rg_wr = 0; o.rg_wr_imm = 0; o.mem_rd = 0; o.mem_wr = 0;
    o.rt = 0; o.rd = 0; o.alu = 0; o.st = 0; o.rdata = 0; o.delay = 0;
    return o;
  endfunction

  initial begin
    op_t         op;
    logic [31:0] tmp;
    int          kind;
    int          r;

    dm_if.dm_ack   = 1'b0;
    dm_if.dm_rdata = '0;

    step();
    chk("rst_ready", o_ready, 1);
    chk("rst_req", dm_if.dm_req, 0);
    step();
    i_rst_n = 1'b1;
    step();
    chk("rst_valid", o_valid, 0);
    chk("rst_exc", o_exc, 0);
    chk("rst_alu", o_alu_data, 0);
    chk("rst_ld", o_mem_rd_data, 0);
    chk("rst_we", dm_if.dm_we, 0);

    op = blank_op(); op.rg_wr = 1; op.rd = 5; op.alu = 32'h1234;
    run_txn("alu_op", op);

    op = blank_op(); op.mem_rd = 1; op.rt = 9; op.alu = 32'h100; op.rdata = 32'hDEADBEEF; op.delay = 3;
    run_txn("load", op);

    op = blank_op(); op.mem_wr = 1; op.alu = 32'h204; op.st = 32'hA5A5A5A5; op.delay = 1;
    run_txn("store", op);

    op = blank_op(); op.mem_rd = 1; op.rt = 3; op.alu = 32'h102;
    run_txn("misalign", op);

    op = blank_op(); op.mem_rd = 1; op.mem_wr = 1; op.alu = 32'h40;
    run_txn("illegal", op);

    op = blank_op(); op.mem_rd = 1; op.rt = 7; op.alu = 32'h300; op.delay = 1000;
    run_txn("timeout", op);

    op = blank_op(); op.mem_rd = 1; op.rt = 8; op.alu = 32'h304; op.rdata = 32'h600DF00D; op.delay = TO - 1;
    run_txn("ack_last", op);

    dm_if.dm_ack = 1'b1;
    step();
    dm_if.dm_ack = 1'b0;
    chk("idle_ack_valid", o_valid, 0);
    chk("idle_ack_req", dm_if.dm_req, 0);

    for (int n = 0; n < 40; n++) begin
      op = blank_op();
      kind = $urandom_range(0, 9);
      op.rg_wr = 1'($urandom); op.rg_wr_imm = 1'($urandom);
      op.rt = 5'($urandom); op.rd = 5'($urandom);
      op.st = $urandom; op.rdata = $urandom;
      tmp = $urandom;
      tmp[1:0] = 2'b00;
      if (kind == 8) tmp[1:0] = 2'($urandom_range(1, 3));
      op.alu = tmp;
      op.mem_rd = (kind >= 3 && kind <= 5) || kind == 8 || kind == 9;
      op.mem_wr = (kind == 6 || kind == 7 || kind == 9);
      r = $urandom_range(0, 19);
      op.delay = (r == 0) ? 200 : (r == 1) ? TO - 1 : $urandom_range(0, 5);
      run_txn($sformatf("rnd%0d", n), op);
    end

    op = blank_op(); op.mem_rd = 1; op.rt = 4; op.alu = 32'h500;
    chk("rsta_ready_pre", o_ready, 1);
    i_valid = 1'b1; i_mem_rd = 1'b1; i_rt = op.rt; i_alu_data = op.alu;
    i_rg_wr = 1'b0; i_rg_wr_imm = 1'b0; i_mem_wr = 1'b0;
    step();
    chk("rsta_req", dm_if.dm_req, 1);
    step();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("rsta_req_drop", dm_if.dm_req, 0);
    chk("rsta_ready", o_ready, 1);
    chk("rsta_valid", o_valid, 0);
    step();
    chk("rsta_valid_hold", o_valid, 0);
    chk("rsta_rt", o_rt, 0);
    i_rst_n = 1'b1;
    step();
    chk("rsta_valid_after", o_valid, 0);
    chk("rsta_req_after", dm_if.dm_req, 0);
    $display("txn reset_mid_access: addr=0x%08h", op.alu);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
